i2c_line_conditioner: RTL and testbench
=======================================

// Module: i2c_line_conditioner
// PURPOSE
//  Front end between the open-drain SCL/SDA pads and the I2C slave FSM. Synchronises raw pad
//  reads, rejects glitches shorter than FILTER_CYCLES, and emits single-cycle SCL edge and
//  START/STOP strobes plus a bus-busy flag. Downstream logic sees only clean, clock-aligned events.
// PARAMETERS
//  FILTER_CYCLES   3     consecutive disagreeing samples needed to flip a filtered line; 0 = bypass
//  TIMEOUT_CYCLES  1000  SCL-low cycles while busy before bus is declared hung (only with macro)
// PORTS
//  clk_i         in   1  system clock; single clock domain
//  rst_ni        in   1  asynchronous, active-low reset
//  scl_i         in   1  raw SCL pad read (asynchronous)
//  sda_i         in   1  raw SDA pad read (asynchronous)
//  scl_o         out  1  filtered SCL level
//  sda_o         out  1  filtered SDA level
//  scl_rise_o    out  1  1-cycle strobe, filtered SCL 0->1
//  scl_fall_o    out  1  1-cycle strobe, filtered SCL 1->0
//  start_o       out  1  1-cycle strobe, START or repeated START
//  stop_o        out  1  1-cycle strobe, STOP
//  busy_o        out  1  high between START and STOP
//  timeout_o     out  1  1-cycle strobe, SCL held low too long (0 without macro)
// BEHAVIOUR
//  - Reset: sync flops, scl_o, sda_o = 1 (idle bus); all strobes, busy_o, counters = 0.
//  - Sync: 2-flop synchroniser per line, reset value 1.
//  - Filter, per line: if sync != filtered, count++; else count = 0. When count reaches
//    FILTER_CYCLES, filtered <= sync, count <= 0. Counter width $clog2(FILTER_CYCLES+1).
//    FILTER_CYCLES=0: filtered <= sync every cycle.
//  - Latency: pad change stable >= FILTER_CYCLES+2 clocks appears on scl_o/sda_o exactly
//    FILTER_CYCLES+2 rising edges after the first edge that samples it. Pulse of
//    <= FILTER_CYCLES clocks (post-sync) never reaches the output.
//  - Edges: prev regs hold last-cycle filtered values. scl_rise_o = scl_o & ~scl_prev,
//    scl_fall_o = ~scl_o & scl_prev. Strobes valid in the same cycle the filtered level changes.
//  - START: sda_prev=1, sda_o=0, scl_prev=1, scl_o=1. STOP: sda_prev=0, sda_o=1, SCL high both.
//    SCL and SDA changing in the same cycle -> no START/STOP (SCL must be high both cycles).
//  - busy_o: set on START, cleared on STOP (registered, visible the cycle after strobe).
//    START while busy (repeated START): start_o pulses, busy_o stays 1.
//    STOP while idle: stop_o pulses, busy_o stays 0.
//  - Reset mid-transfer: all state to reset values immediately; no strobes generated on release,
//    as filtered lines restart at 1 and need FILTER_CYCLES+2 clocks to follow a low pad.
// CONFIGURATION
//  - I2C_LINE_TIMEOUT_EN defined: counter counts cycles with busy_o=1 and scl_o=0; cleared when
//    scl_o=1 or busy_o=0. On reaching TIMEOUT_CYCLES: timeout_o pulses 1 cycle, busy_o <= 0,
//    counter <= 0. Width $clog2(TIMEOUT_CYCLES+1).
//  - Not defined: no counter; timeout_o tied 0; busy_o cleared only by STOP or reset.
// STRUCTURE
//  - Shared header i2c_defs.vh: idle line level constant (1'b1), default FILTER_CYCLES and
//    TIMEOUT_CYCLES, macro I2C_LINE_TIMEOUT_EN documentation.
//  - Sub-module i2c_glitch_filter (sync + counter filter, one line), instantiated for SCL and SDA.
//  - Top holds prev regs, edge/START/STOP decode, busy flag, optional timeout counter.
// TESTING
//  - Reset, pads idle 1 -> scl_o=sda_o=1, all strobes 0, busy_o=0 for 20 clocks.
//  - FILTER_CYCLES=3: SDA pad low 3 clocks then high -> sda_o stays 1; low 6 clocks -> sda_o falls
//    exactly 5 edges after first sampling edge.
//  - SDA falls with SCL high, later SCL toggles 8x, SDA rises with SCL high -> one start_o,
//    8 scl_rise_o + 8 scl_fall_o, one stop_o; busy_o high between them.
//  - Repeated START mid-frame -> second start_o pulse, busy_o never drops; SCL and SDA forced
//    low in same pad cycle -> no start_o.
//  - With I2C_LINE_TIMEOUT_EN, TIMEOUT_CYCLES=50: START then SCL held low 60 clocks -> timeout_o
//    pulses once at 50th low cycle, busy_o=0 next cycle; without macro busy_o stays 1.
//  - Assert rst_ni mid-byte (SDA low) -> outputs return to reset values same cycle; after release
//    no start_o/stop_o glitch.

Source files
------------

// File: rtl/i2c_line_conditioner_pkg.sv
// Shared constants for the I2C line conditioner: idle line level and parameter defaults.
// Optional feature macro: I2C_LINE_TIMEOUT_EN enables the SCL-held-low timeout counter,
// which drops busy_o and pulses timeout_o when the bus hangs mid-transfer.
package i2c_line_conditioner_pkg;

  // Open-drain bus idles high; every line-state flop resets to this value.
  localparam logic IDLE_LVL = 1'b1;

  localparam int unsigned DEF_FILTER_CYCLES  = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

  // Filtered level of both lines for one cycle.
  typedef struct packed {
    logic scl;
    logic sda;
  } i2c_lines_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Purpose: 2-flop synchroniser plus run-length glitch filter for one open-drain line.
// Ports:   clk_i, rst_ni (async active-low), line_i (raw pad), line_o (filtered level).
// A level change must persist FILTER_CYCLES+1 synchronised samples before line_o follows;
// FILTER_CYCLES = 0 passes the synchronised level straight through (one register stage).
module i2c_glitch_filter
  import i2c_line_conditioner_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_o
);

  logic [1:0] sync_q;
  logic       filt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  if (FILTER_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        filt_q <= IDLE_LVL;
      end else begin
        filt_q <= sync_q[1];
      end
    end
  end else begin : g_filter
    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_d;

    // The counter saturates at FILTER_CYCLES; one further disagreeing sample flips the
    // output, so a post-sync pulse of FILTER_CYCLES clocks or fewer is always absorbed.
    always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[1] != filt_q) begin
        if (cnt_q == CW'(FILTER_CYCLES)) begin
          filt_d = sync_q[1];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        filt_q <= IDLE_LVL;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/i2c_line_conditioner.sv
// Purpose: clean SCL/SDA front end for an I2C slave: filtered levels, SCL edge strobes,
//          START/STOP strobes and a bus-busy flag.
// Ports:   clk_i, rst_ni (async active-low); scl_i/sda_i raw pads; scl_o/sda_o filtered;
//          scl_rise_o, scl_fall_o, start_o, stop_o, timeout_o single-cycle strobes; busy_o level.
// Macro I2C_LINE_TIMEOUT_EN adds the SCL-low hang detector; without it timeout_o is tied 0.
module i2c_line_conditioner
  import i2c_line_conditioner_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o,
  output logic timeout_o
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  i2c_lines_t cur, prev_q;
  logic       busy_q, busy_d;
  logic       timeout;

  i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (scl_i),
    .line_o (cur.scl)
  );

  i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (sda_i),
    .line_o (cur.sda)
  );

  // Previous levels reset to idle so leaving reset never fabricates an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '{scl: IDLE_LVL, sda: IDLE_LVL};
    end else begin
      prev_q <= cur;
    end
  end

  assign scl_rise_o = cur.scl & ~prev_q.scl;
  assign scl_fall_o = ~cur.scl & prev_q.scl;
  // SCL must be high in both cycles, so a simultaneous SCL+SDA change is not a condition.
  assign start_o    = prev_q.scl & cur.scl & prev_q.sda & ~cur.sda;
  assign stop_o     = prev_q.scl & cur.scl & ~prev_q.sda & cur.sda;

`ifdef I2C_LINE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Strobe fires during the TIMEOUT_CYCLES-th consecutive busy/SCL-low cycle.
  assign timeout = busy_q & ~cur.scl & (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (busy_q && !cur.scl && !timeout) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // START (including repeated START) wins; STOP or hang detection release the bus.
  always_comb begin
    busy_d = busy_q;
    if (start_o) begin
      busy_d = 1'b1;
    end else if (stop_o || timeout) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign scl_o     = cur.scl;
  assign sda_o     = cur.sda;
  assign busy_o    = busy_q;
  assign timeout_o = timeout;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
module tb_i2c_line_conditioner;

  localparam int F = 3;
  localparam int T = 50;
`ifdef I2C_LINE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic scl_i = 1'b1;
  logic sda_i = 1'b1;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;

  i2c_line_conditioner #(.FILTER_CYCLES(F), .TIMEOUT_CYCLES(T)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_rise_o (scl_rise_o),
    .scl_fall_o (scl_fall_o),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-line sample history (index 0 = newest pad sample). The filtered
  // level flips when the F+1 most recent post-synchroniser samples all disagree with it.
  bit sh_s[$];
  bit sh_d[$];
  bit m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_tmo;
  int m_run;

  function automatic bit window_disagrees(input bit q[$], input bit lvl);
    for (int j = 2; j <= 2 + F; j++)
      if (q[j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    sh_s.delete();
    sh_d.delete();
    for (int j = 0; j < F + 3; j++) begin
      sh_s.push_back(1'b1);
      sh_d.push_back(1'b1);
    end
    m_scl = 1; m_sda = 1;
    m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_busy = 0; m_tmo = 0;
    m_run = 0;
  endtask

  task automatic model_step(input bit s, input bit d);
    bit ns, nd;
    // busy reflects last cycle's bus conditions
    if (m_start) m_busy = 1;
    else if (m_stop || m_tmo) m_busy = 0;
    sh_s.push_front(s); void'(sh_s.pop_back());
    sh_d.push_front(d); void'(sh_d.pop_back());
    ns = window_disagrees(sh_s, m_scl) ? ~m_scl : m_scl;
    nd = window_disagrees(sh_d, m_sda) ? ~m_sda : m_sda;
    m_rise  = ns & ~m_scl;
    m_fall  = ~ns & m_scl;
    m_start = m_scl & ns & m_sda & ~nd;
    m_stop  = m_scl & ns & ~m_sda & nd;
    m_scl = ns;
    m_sda = nd;
    m_tmo = 0;
    if (TMO_EN) begin
      if (m_busy && !m_scl) m_run++;
      else m_run = 0;
      if (m_run == T) begin
        m_tmo = 1;
        m_run = 0;
      end
    end
  endtask

  int c_start, c_stop, c_rise, c_fall, c_tmo, c_sda_low, c_idle;

  task automatic reset_counts();
    c_start = 0; c_stop = 0; c_rise = 0; c_fall = 0; c_tmo = 0; c_sda_low = 0; c_idle = 0;
  endtask

  function automatic logic [31:0] dut_vec();
    return {24'd0, scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o};
  endfunction

  function automatic logic [31:0] model_vec();
    return {24'd0, m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_tmo};
  endfunction

  // One clock: model consumes the pad levels present at the rising edge; outputs are
  // compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_ni) model_step(scl_i, sda_i);
    @(negedge clk);
    chk("cycle", dut_vec(), model_vec());
    c_start   += int'(start_o);
    c_stop    += int'(stop_o);
    c_rise    += int'(scl_rise_o);
    c_fall    += int'(scl_fall_o);
    c_tmo     += int'(timeout_o);
    c_sda_low += int'(!sda_o);
    c_idle    += int'(!busy_o);
  endtask

  task automatic hold(input bit s, input bit d, input int n);
    scl_i = s;
    sda_i = d;
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    #2 rst_ni = 1'b0;
    @(negedge clk);
    chk("reset_vec", dut_vec(), 32'hC0);
    @(negedge clk);
    rst_ni = 1'b1;

    // idle after reset
    reset_counts();
    hold(1, 1, 20);
    chk("idle_strobes", c_start + c_stop + c_rise + c_fall + c_tmo + c_sda_low, 0);
    chk("idle_busy", busy_o, 0);

    // glitch of F clocks is absorbed
    reset_counts();
    hold(1, 0, 3);
    hold(1, 1, 10);
    chk("glitch_sda", c_sda_low, 0);
    chk("glitch_start", c_start, 0);

    // latency: 6-clock low pulse, falls on the F+2 edge after the first sampling edge
    sda_i = 1'b0;
    repeat (5) cycle();
    chk("lat_before", sda_o, 1);
    cycle();
    chk("lat_at", sda_o, 0);
    hold(1, 1, 10);

    // full frame: START, 8 SCL pulses, STOP
    reset_counts();
    hold(1, 0, 8);
    for (int i = 0; i < 8; i++) begin
      hold(0, 0, 8);
      hold(1, 0, 8);
    end
    hold(1, 1, 8);
    chk("frame_start", c_start, 1);
    chk("frame_stop", c_stop, 1);
    chk("frame_rise", c_rise, 8);
    chk("frame_fall", c_fall, 8);
    chk("frame_busy_end", busy_o, 0);

    // repeated START keeps the bus busy
    reset_counts();
    hold(1, 0, 8);
    c_idle = 0;
    hold(0, 0, 8);
    hold(0, 1, 8);
    hold(1, 1, 8);
    hold(1, 0, 8);
    chk("rstart_count", c_start, 2);
    chk("rstart_idle", c_idle, 0);
    hold(0, 0, 8);
    hold(1, 0, 8);
    hold(1, 1, 8);
    chk("rstart_stop", c_stop, 1);

    // SCL and SDA moving together is neither START nor STOP
    reset_counts();
    hold(0, 0, 10);
    hold(1, 1, 10);
    chk("simul_start", c_start, 0);
    chk("simul_stop", c_stop, 0);

    // SCL stuck low while busy
    reset_counts();
    hold(1, 0, 8);
    hold(0, 0, 60);
    chk("tmo_pulses", c_tmo, TMO_EN ? 1 : 0);
    chk("tmo_busy", busy_o, TMO_EN ? 0 : 1);
    hold(1, 0, 8);
    hold(1, 1, 8);
    chk("tmo_recover_busy", busy_o, 0);

    // reset mid-byte with SDA low
    hold(1, 0, 8);
    hold(0, 0, 8);
    #1 rst_ni = 1'b0;
    #1 chk("rst_mid_vec", dut_vec(), 32'hC0);
    model_reset();
    repeat (2) cycle();
    rst_ni = 1'b1;
    reset_counts();
    repeat (12) cycle();
    chk("rst_rel_start", c_start, 0);
    chk("rst_rel_stop", c_stop, 0);
    hold(1, 1, 10);

    // random pad activity including short glitches
    repeat (300) hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 9));
    hold(1, 1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
